// File: rtl/ocm_fir_sample_streamer.sv
// ocm_fir_sample_streamer
//   Reads N consecutive words from the on-chip sample buffer (Avalon-MM read
//   master on the s2 port) and replays them as an Avalon-ST source into the
//   FIR compiler sink, one sample every max(sample_div+1, RD_LAT+2) cycles.
//
// Ports
//   clk_clk, reset_reset          clock, asynchronous active-high reset
//   start, abort                  run control (start pulse, abort level)
//   base_addr, num_samples,       run configuration, latched on an accepted start
//   sample_div
//   loop_en                       live; decides loop vs stop at the end of each pass
//   busy, done                    run status (done is a 1-cycle pulse)
//   ocm_*                         Avalon-MM read master towards the s2 port
//   st_data, st_valid, st_error   Avalon-ST source towards the FIR sink
//   dbg_state                     current FSM state, for observation only
//
// Handshake: the FIR sink has no backpressure, so a sample is transferred in
// every cycle where st_valid is 1; there is no ready. On the s2 side a read is
// issued by a single chipselect cycle and ocm_readdata is valid RD_LAT cycles
// later; no waitrequest exists.
module ocm_fir_sample_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16,
  parameter int LEN_W  = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_samples,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ocm_address,
  output logic              ocm_chipselect,
  output logic              ocm_clken,
  output logic              ocm_write,
  output logic [DATA_W-1:0] ocm_writedata,
  output logic [1:0]        ocm_byteenable,
  input  logic [DATA_W-1:0] ocm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  output logic [1:0]        st_error,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam logic [1:0] LP_WLAST = 2'(RD_LAT - 1);

  state_t            r_state;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_base;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_ptimer;
  logic [1:0]        r_wcnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_fin;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cs;
  logic [DATA_W-1:0] r_st_data;
  logic              r_st_valid;

  state_t            w_state_n;
  logic [LEN_W-1:0]  w_idx_n;
  logic [LEN_W-1:0]  w_idx_inc;
  logic [ADDR_W-1:0] w_base_sel;
  logic [ADDR_W-1:0] w_addr_n;
  logic              w_accept;
  logic              w_len_zero;
  logic              w_rd_last;
  logic              w_emit;
  logic              w_last;
  logic              w_fin_n;

  assign w_idx_inc  = r_idx + LEN_W'(1);
  // In IDLE the configuration is not latched yet, so the first address
  // comes straight from the input port.
  assign w_base_sel = (r_state == S_IDLE) ? base_addr : r_base;
  assign w_addr_n   = w_base_sel + ADDR_W'(w_idx_n);

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_fin_n    = 1'b0;
    // r_busy is still high for the one cycle after the final sample (done is
    // pending), so a start in that cycle is ignored as well.
    w_accept   = (r_state == S_IDLE) && !r_busy && start && !abort;
    w_len_zero = (num_samples == '0);
    w_rd_last  = (r_wcnt == LP_WLAST);
    w_emit     = (r_state == S_EMIT) && (r_ptimer >= r_div) && !abort;
    w_last     = (w_idx_inc == r_len);
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_len_zero) begin
          w_state_n = S_READ;
          w_idx_n   = '0;
        end
      end
      S_READ: w_state_n = S_WAIT;
      S_WAIT: begin
        if (w_rd_last) w_state_n = S_EMIT;
      end
      S_EMIT: begin
        if (w_emit) begin
          if (!w_last) begin
            w_state_n = S_READ;
            w_idx_n   = w_idx_inc;
          end else if (loop_en) begin
            w_state_n = S_READ;
            w_idx_n   = '0;
          end else begin
            w_state_n = S_IDLE;
            w_fin_n   = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // abort overrides everything, including a final emit in this cycle
    if (abort) begin
      w_state_n = S_IDLE;
      w_fin_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_div      <= '0;
      r_ptimer   <= '0;
      r_wcnt     <= '0;
      r_hold     <= '0;
      r_fin      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_cs       <= 1'b0;
      r_st_data  <= '0;
      r_st_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      if (w_accept) begin
        r_len  <= num_samples;
        r_base <= base_addr;
        r_div  <= sample_div;
      end
      // Strobe and address are registered from the next state so that they
      // are high exactly during the READ cycle.
      r_cs <= (w_state_n == S_READ);
      if (w_state_n == S_READ) r_addr <= w_addr_n;
      // The period timer is 0 in the READ cycle and saturates rather than wraps.
      if (w_state_n == S_READ)  r_ptimer <= '0;
      else if (r_ptimer != '1)  r_ptimer <= r_ptimer + DIV_W'(1);
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 2'd1 : 2'd0;
      if (r_state == S_WAIT && w_rd_last) r_hold <= ocm_readdata;
      r_st_valid <= w_emit;
      if (w_emit) r_st_data <= r_hold;
      r_fin  <= w_fin_n;
      r_done <= (w_accept && w_len_zero) || (r_fin && !abort);
      if (abort)                         r_busy <= 1'b0;
      else if (w_accept && !w_len_zero)  r_busy <= 1'b1;
      else if (r_fin)                    r_busy <= 1'b0;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign ocm_address    = r_addr;
  assign ocm_chipselect = r_cs;
  assign ocm_clken      = 1'b1;
  assign ocm_write      = 1'b0;
  assign ocm_writedata  = '0;
  assign ocm_byteenable = 2'b11;
  assign st_data        = r_st_data;
  assign st_valid       = r_st_valid;
  assign st_error       = 2'b00;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ocm_fir_sample_streamer.sv
// Directed bench for ocm_fir_sample_streamer: behavioural s2 memory with one
// cycle read latency, a negedge monitor logging every st_valid / done /
// chipselect event with its cycle number, and hand-computed expectations
// relative to the cycle in which start was driven high.
module tb_ocm_fir_sample_streamer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DIV_W  = 16;
  localparam int LEN_W  = 17;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_samples;
  logic [DIV_W-1:0]  sample_div;
  logic              loop_en;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ocm_address;
  logic              ocm_chipselect;
  logic              ocm_clken;
  logic              ocm_write;
  logic [DATA_W-1:0] ocm_writedata;
  logic [1:0]        ocm_byteenable;
  logic [DATA_W-1:0] ocm_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic [1:0]        st_error;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:65535];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_dbl = 0;
  logic prev_valid = 1'b0;

  int                v_cyc_q[$];
  logic [DATA_W-1:0] v_data_q[$];
  int                d_cyc_q[$];
  int                cs_cyc_q[$];
  logic [ADDR_W-1:0] a_q[$];
  logic [DATA_W-1:0] exp_q[$];

  ocm_fir_sample_streamer dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_samples(num_samples), .sample_div(sample_div),
    .loop_en(loop_en), .busy(busy), .done(done), .ocm_address(ocm_address),
    .ocm_chipselect(ocm_chipselect), .ocm_clken(ocm_clken), .ocm_write(ocm_write),
    .ocm_writedata(ocm_writedata), .ocm_byteenable(ocm_byteenable),
    .ocm_readdata(ocm_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_error(st_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset-independent infrastructure ----------------
  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // s2 memory model, RD_LAT = 1
  always @(posedge clk_clk) if (ocm_chipselect) ocm_readdata <= mem[ocm_address];

  always @(negedge clk_clk) begin
    if (st_valid) begin
      v_cyc_q.push_back(cyc);
      v_data_q.push_back(st_data);
      if (prev_valid) n_dbl++;
    end
    prev_valid = st_valid;
    if (done) d_cyc_q.push_back(cyc);
    if (ocm_chipselect) begin
      cs_cyc_q.push_back(cyc);
      a_q.push_back(ocm_address);
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic clear_logs();
    v_cyc_q.delete(); v_data_q.delete(); d_cyc_q.delete();
    cs_cyc_q.delete(); a_q.delete(); exp_q.delete();
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n,
                          input logic [DIV_W-1:0] d, input logic lp, output int s);
    base_addr = b; num_samples = n; sample_div = d; loop_en = lp;
    start = 1'b1;
    s = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the logged stream against exp_q and a fixed period.
  task automatic chk_stream(input string tag, input int first, input int period);
    chk({tag, "_count"}, v_data_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_data"}, (i < v_data_q.size()) ? 32'(v_data_q[i]) : 32'hdead, 32'(exp_q[i]));
      chk({tag, "_cyc"}, (i < v_cyc_q.size()) ? v_cyc_q[i] : -1, first + period * i);
    end
  endtask

  // ---------------- directed sequence ----------------
  int s;

  initial begin
    reset_reset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    base_addr = '0; num_samples = '0; sample_div = '0;
    mem[16'h0010] = 16'h1111; mem[16'h0011] = 16'h2222;
    mem[16'h0012] = 16'h3333; mem[16'h0013] = 16'h4444;
    mem[16'h0020] = 16'hA001; mem[16'h0021] = 16'hA002; mem[16'h0022] = 16'hA003;
    mem[16'hFFFE] = 16'hB001; mem[16'hFFFF] = 16'hB002;
    mem[16'h0000] = 16'hB003; mem[16'h0001] = 16'hB004;
    mem[16'h0030] = 16'h0AAA; mem[16'h0031] = 16'h0BBB;
    for (int i = 0; i < 8; i++) mem[16'h0040 + i] = 16'hC000 + 16'(i);
    tick(3);

    // reset state and constant outputs
    chk("rst_ctl", {busy, done, ocm_chipselect, st_valid}, 4'b0000);
    chk("rst_addr", ocm_address, 16'h0000);
    chk("rst_data", st_data, 16'h0000);
    chk("rst_state", dbg_state, 2'd0);
    chk("consts", {ocm_clken, ocm_write, ocm_writedata, ocm_byteenable, st_error},
        {1'b1, 1'b0, 16'h0000, 2'b11, 2'b00});
    reset_reset = 1'b0;
    tick(2);

    // 1: four samples, div=9 -> period 10, first valid 11 cycles after start
    clear_logs();
    do_start(16'h0010, 17'd4, 16'd9, 1'b0, s);
    wait_until(s + 60);
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    chk_stream("t1", s + 11, 10);
    chk("t1_done_n", d_cyc_q.size(), 1);
    chk("t1_done_cyc", (d_cyc_q.size() > 0) ? d_cyc_q[0] : -1, s + 42);
    chk("t1_addr0", (a_q.size() > 0) ? 32'(a_q[0]) : 32'hdead, 16'h0010);
    chk("t1_busy", busy, 1'b0);

    // 2: div=0 -> period RD_LAT+2 = 3 for both valid and chipselect
    clear_logs();
    do_start(16'h0020, 17'd3, 16'd0, 1'b0, s);
    wait_until(s + 20);
    exp_q = '{16'hA001, 16'hA002, 16'hA003};
    chk_stream("t2", s + 4, 3);
    chk("t2_cs_n", cs_cyc_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t2_cs_cyc", (i < cs_cyc_q.size()) ? cs_cyc_q[i] : -1, s + 1 + 3 * i);
    chk("t2_done_cyc", (d_cyc_q.size() > 0) ? d_cyc_q[0] : -1, s + 11);

    // 3: address wrap at the top of memory
    clear_logs();
    do_start(16'hFFFE, 17'd4, 16'd2, 1'b0, s);
    wait_until(s + 25);
    exp_q = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
    chk_stream("t3", s + 4, 3);
    chk("t3_a0", (a_q.size() > 0) ? 32'(a_q[0]) : 32'hdead, 16'hFFFE);
    chk("t3_a1", (a_q.size() > 1) ? 32'(a_q[1]) : 32'hdead, 16'hFFFF);
    chk("t3_a2", (a_q.size() > 2) ? 32'(a_q[2]) : 32'hdead, 16'h0000);
    chk("t3_a3", (a_q.size() > 3) ? 32'(a_q[3]) : 32'hdead, 16'h0001);

    // 4: looping A,B,A,B; loop_en cleared during the second B fetch
    clear_logs();
    do_start(16'h0030, 17'd2, 16'd3, 1'b1, s);
    wait_until(s + 14);
    loop_en = 1'b0;
    wait_until(s + 40);
    exp_q = '{16'h0AAA, 16'h0BBB, 16'h0AAA, 16'h0BBB};
    chk_stream("t4", s + 5, 4);
    chk("t4_done_n", d_cyc_q.size(), 1);
    chk("t4_done_cyc", (d_cyc_q.size() > 0) ? d_cyc_q[0] : -1, s + 18);

    // 5: start while busy ignored; abort two cycles before the third sample
    clear_logs();
    do_start(16'h0040, 17'd8, 16'd4, 1'b0, s);
    wait_until(s + 3);
    base_addr = 16'h0080; num_samples = 17'd1; sample_div = 16'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_until(s + 14);
    chk("t5_busy_pre", busy, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_busy_post", busy, 1'b0);
    chk("t5_valid_post", st_valid, 1'b0);
    wait_until(s + 40);
    exp_q = '{16'hC000, 16'hC001};
    chk_stream("t5", s + 6, 5);
    chk("t5_done_n", d_cyc_q.size(), 0);
    chk("t5_cs_n", a_q.size(), 3);
    chk("t5_a2", (a_q.size() > 2) ? 32'(a_q[2]) : 32'hdead, 16'h0042);

    // 6a: zero-length start
    clear_logs();
    do_start(16'h0010, 17'd0, 16'd5, 1'b0, s);
    chk("t6_zero_done", {busy, done}, 2'b01);
    wait_until(s + 10);
    chk("t6_zero_done_n", d_cyc_q.size(), 1);
    chk("t6_zero_cs", cs_cyc_q.size(), 0);
    chk("t6_zero_valid", v_cyc_q.size(), 0);

    // 6b: reset mid-run, then a fresh run
    clear_logs();
    do_start(16'h0010, 17'd4, 16'd9, 1'b0, s);
    wait_until(s + 5);
    #3 reset_reset = 1'b1;
    #1;
    chk("t6_rst_ctl", {busy, done, ocm_chipselect, st_valid}, 4'b0000);
    chk("t6_rst_addr", ocm_address, 16'h0000);
    chk("t6_rst_data", st_data, 16'h0000);
    @(posedge clk_clk);
    #1 reset_reset = 1'b0;
    tick(2);
    chk("t6_rst_nodone", d_cyc_q.size(), 0);
    clear_logs();
    do_start(16'h0010, 17'd4, 16'd1, 1'b0, s);
    wait_until(s + 25);
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    chk_stream("t6", s + 4, 3);
    chk("t6_done_cyc", (d_cyc_q.size() > 0) ? d_cyc_q[0] : -1, s + 14);

    chk("no_back_to_back", n_dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
